// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       rx_hold;
    modport master (output tx_data, tx_req, input tx_busy, tx_done, tx_error, rx_hold);
    modport slave  (input tx_data, tx_req, output tx_busy, tx_done, tx_error, rx_hold);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter driving open-collector pads via output enables.
// Define PS2_TX_RETRY_EN to retry a failed frame up to twice before reporting tx_error.
module ps2_host_tx #(
    parameter int CLK_FREQ         = 28_000_000,
    parameter int INHIBIT_US       = 120,
    parameter int FIRST_TIMEOUT_US = 15000,
    parameter int BIT_TIMEOUT_US   = 2000,
    parameter int FILTER_LEN       = 8
) (
    input  logic         clk28,
    input  logic         usrrst_n,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    localparam int CPU   = CLK_FREQ / 1_000_000;
    localparam int INH_N = CPU * INHIBIT_US;
    localparam int RTS_N = CPU * 2;
    localparam int T1_N  = CPU * FIRST_TIMEOUT_US;
    localparam int TB_N  = CPU * BIT_TIMEOUT_US;
    localparam int CMAX  = (T1_N > INH_N) ? ((T1_N > TB_N) ? T1_N : TB_N) : ((INH_N > TB_N) ? INH_N : TB_N);
    localparam int CW    = $clog2(CMAX + 1);
    localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, ERR} state_t;

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_s, dat_s;
    logic          clk_f_q, clk_f_d, flt_hit, fall;
    logic [FW-1:0] flt_q, flt_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          accept, fail;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]    data_q, data_d;
    logic [1:0]    retry_q, retry_d;
`endif

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // The clock level only flips after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        flt_hit = (clk_s != clk_f_q) && (flt_q == FLT_MAX);
        clk_f_d = flt_hit ? clk_s : clk_f_q;
        flt_d   = (clk_s == clk_f_q || flt_hit) ? '0 : flt_q + 1'b1;
        fall    = clk_f_q & ~clk_f_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        dat_oe_d = dat_oe_q;
        fail     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        data_d   = data_q;
        retry_d  = retry_q;
`endif
        accept   = (state_q == IDLE) && tx.tx_req && !done_q && !err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = INHIBIT;
                cnt_d   = CW'(INH_N);
                shift_d = frame_of(tx.tx_data);
`ifdef PS2_TX_RETRY_EN
                data_d  = tx.tx_data;
                retry_d = 2'd0;
`endif
            end
            INHIBIT: if (cnt_q == CW'(1)) begin
                state_d  = RTS;
                cnt_d    = CW'(RTS_N);
                dat_oe_d = 1'b1;
            end else cnt_d = cnt_q - 1'b1;
            RTS: if (cnt_q == CW'(1)) begin
                state_d = SEND;
                cnt_d   = CW'(T1_N);
                bit_d   = 4'd0;
            end else cnt_d = cnt_q - 1'b1;
            SEND: if (fall) begin
                dat_oe_d = ~shift_q[0];
                shift_d  = {1'b0, shift_q[9:1]};
                bit_d    = bit_q + 1'b1;
                cnt_d    = CW'(TB_N);
                state_d  = (bit_q == 4'd9) ? ACK : SEND;
            end else if (cnt_q == CW'(1)) fail = 1'b1;
            else cnt_d = cnt_q - 1'b1;
            ACK: if (fall) begin
                fail    = dat_s;
                state_d = WAIT_IDLE;
                cnt_d   = CW'(TB_N);
            end else if (cnt_q == CW'(1)) fail = 1'b1;
            else cnt_d = cnt_q - 1'b1;
            WAIT_IDLE: if (clk_f_q && dat_s) state_d = IDLE;
            else if (cnt_q == CW'(1)) fail = 1'b1;
            else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                state_d = INHIBIT;
                cnt_d   = CW'(INH_N);
                shift_d = frame_of(data_q);
                retry_d = retry_q + 1'b1;
            end else state_d = ERR;
`else
            state_d = ERR;
`endif
        end
        if (state_d != RTS && state_d != SEND) dat_oe_d = 1'b0;
        clk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
        busy_d   = (state_d != IDLE) && (state_d != ERR);
        done_d   = (state_q == WAIT_IDLE) && (state_d == IDLE);
        err_d    = (state_d == ERR);
    end

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_f_q    <= 1'b1;
            flt_q      <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            data_q     <= '0;
            retry_q    <= '0;
`endif
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_f_q    <= clk_f_d;
            flt_q      <= flt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PS2_TX_RETRY_EN
            data_q     <= data_d;
            retry_q    <= retry_d;
`endif
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign tx.tx_busy  = busy_q;
    assign tx.rx_hold  = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.tx_error = err_q;
endmodule
